// File: rtl/mac_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mac_reg_arbiter
// Brief    : Round-robin arbiter sharing the MAC config register bus between
//            the init sequencer, the host command path and the stats poller.
// Revision : 1.0  initial release
// ============================================================================
module mac_reg_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_init_done,
  input  logic [2:0]  i_req_rd,
  input  logic [2:0]  i_req_wr,
  input  logic [23:0] i_req_addr,
  input  logic [95:0] i_req_wdata,
  output logic [31:0] o_rsp_rdata,
  output logic [2:0]  o_rsp_done,
  output logic [2:0]  o_rsp_err,
  output logic [7:0]  o_mac_addr,
  output logic [31:0] o_mac_writedata,
  input  logic [31:0] i_mac_readdata,
  output logic        o_mac_rd,
  output logic        o_mac_wr,
  input  logic        i_mac_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_gnt;
  logic            r_busy_d;
  logic [TO_W-1:0] r_cnt;

  logic [2:0]      w_elig;
  logic            w_found;
  logic [1:0]      w_pick;
  logic [7:0]      w_addr;
  logic [31:0]     w_wdata;
  logic            w_done_ok;
  logic            w_tmo;

  function automatic logic [1:0] f_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Ports 1 and 2 stay locked out until the init sequence reports completion.
  assign w_elig    = (i_req_rd | i_req_wr) & {i_init_done, i_init_done, 1'b1};
  assign w_done_ok = r_busy_d & ~i_mac_busy;
  assign w_tmo     = (r_cnt == C_TO_LAST);

  always_comb begin
    logic [1:0] v_p;
    w_found = 1'b0;
    w_pick  = 2'd0;
    v_p     = r_last;
    for (int k = 0; k < 3; k++) begin
      v_p = f_next(v_p);
      if (!w_found && w_elig[v_p]) begin
        w_found = 1'b1;
        w_pick  = v_p;
      end
    end
  end

  always_comb begin
    case (w_pick)
      2'd1: begin
        w_addr  = i_req_addr[15:8];
        w_wdata = i_req_wdata[63:32];
      end
      2'd2: begin
        w_addr  = i_req_addr[23:16];
        w_wdata = i_req_wdata[95:64];
      end
      default: begin
        w_addr  = i_req_addr[7:0];
        w_wdata = i_req_wdata[31:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_last          <= 2'd2;
      r_gnt           <= 2'd0;
      r_busy_d        <= 1'b0;
      r_cnt           <= '0;
      o_mac_rd        <= 1'b0;
      o_mac_wr        <= 1'b0;
      o_mac_addr      <= 8'd0;
      o_mac_writedata <= 32'd0;
      o_rsp_rdata     <= 32'd0;
      o_rsp_done      <= 3'd0;
      o_rsp_err       <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_rsp_done <= 3'd0;
          o_rsp_err  <= 3'd0;
          if (w_found) begin
            r_gnt           <= w_pick;
            o_mac_addr      <= w_addr;
            o_mac_writedata <= w_wdata;
            r_busy_d        <= 1'b0;
            r_cnt           <= '0;
            if (i_req_rd[w_pick] && i_req_wr[w_pick]) begin
              // Ambiguous request: report an error without touching the bus.
              o_rsp_done <= 3'b001 << w_pick;
              o_rsp_err  <= 3'b001 << w_pick;
              r_state    <= S_DONE;
            end else begin
              o_mac_rd <= i_req_rd[w_pick];
              o_mac_wr <= i_req_wr[w_pick];
              r_state  <= S_XFER;
            end
          end
        end

        S_XFER: begin
          r_busy_d <= i_mac_busy;
          if (w_done_ok) begin
            o_mac_rd <= 1'b0;
            o_mac_wr <= 1'b0;
            if (o_mac_rd) begin
              o_rsp_rdata <= i_mac_readdata;
            end
            o_rsp_done <= 3'b001 << r_gnt;
            o_rsp_err  <= 3'd0;
            r_state    <= S_DONE;
          end else if (w_tmo) begin
            o_mac_rd   <= 1'b0;
            o_mac_wr   <= 1'b0;
            o_rsp_done <= 3'b001 << r_gnt;
            o_rsp_err  <= 3'b001 << r_gnt;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end

        S_DONE: begin
          o_rsp_done <= 3'd0;
          o_rsp_err  <= 3'd0;
          r_last     <= r_gnt;
          r_state    <= S_IDLE;
        end

        default: begin
          o_mac_rd <= 1'b0;
          o_mac_wr <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
